spi_master_arbiter: RTL and testbench

//  Shares one SPI_Master among NUM_REQ client blocks. Picks one pending

---
 rtl/spi_master_arbiter_if.sv | 34 +++
 rtl/spi_master_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_master_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arbiter_if.sv
// Client-side request/response bus plus the shared SPI master hookup, bundled
// so the arbiter and its environment see one port each.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_timeout;
  logic                          busy;
  logic                          spi_start;
  logic [DATA_WIDTH-1:0]         spi_data_in;
  logic                          spi_finish;
  logic [DATA_WIDTH-1:0]         spi_data_out;
  logic                          spi_cs_in;
  logic [NUM_REQ-1:0]            cs_n;

  // Arbiter side: drives grants/responses and the master's start/data_in.
  modport master (
    input  req, req_data, spi_finish, spi_data_out, spi_cs_in,
    output gnt, rsp_valid, rsp_data, rsp_timeout, busy,
           spi_start, spi_data_in, cs_n
  );

  // Environment side: clients plus the SPI master itself.
  modport slave (
    output req, req_data, spi_finish, spi_data_out, spi_cs_in,
    input  gnt, rsp_valid, rsp_data, rsp_timeout, busy,
           spi_start, spi_data_in, cs_n
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ clients, with a
// watchdog that completes the transaction if the master never finishes.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_WAIT, S_RESP} state_t;

  state_t                state_reg;
  logic [PTR_W-1:0]      ptr_reg;
  logic [PTR_W-1:0]      owner_reg;
  logic [CNT_W-1:0]      wd_cnt_reg;
  logic [NUM_REQ-1:0]    gnt_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [DATA_WIDTH-1:0] spi_data_in_reg;
  logic                  rsp_timeout_reg;
  logic                  busy_reg;
  logic                  spi_start_reg;

  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W:0]        scan_idx;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      // Only the current owner's select follows the master, and only while busy.
      assign bus.cs_n[gi] = (busy_reg && owner_reg == PTR_W'(gi)) ? bus.spi_cs_in : 1'b1;
    end
  endgenerate

  // Scan downwards so the last hit is the nearest set bit at or after ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      if (bus.req[scan_idx[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      wd_cnt_reg      <= '0;
      gnt_reg         <= '0;
      rsp_valid_reg   <= '0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
      spi_start_reg   <= 1'b0;
      spi_data_in_reg <= '0;
      busy_reg        <= 1'b0;
    end else begin
      gnt_reg       <= '0;
      rsp_valid_reg <= '0;
      spi_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            owner_reg       <= pick_idx;
            spi_data_in_reg <= req_word[pick_idx];
            gnt_reg         <= NUM_REQ'(1) << pick_idx;
            busy_reg        <= 1'b1;
            state_reg       <= S_GRANT;
          end
        end
        S_GRANT: begin
          spi_start_reg <= 1'b1;
          state_reg     <= S_START;
        end
        S_START: begin
          wd_cnt_reg <= '0;
          state_reg  <= S_WAIT;
        end
        S_WAIT: begin
          // Finish takes priority over a watchdog expiring in the same cycle.
          if (bus.spi_finish) begin
            rsp_data_reg    <= bus.spi_data_out;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= NUM_REQ'(1) << owner_reg;
            state_reg       <= S_RESP;
          end else if (wd_cnt_reg == WD_LAST) begin
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= NUM_REQ'(1) << owner_reg;
            state_reg       <= S_RESP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          ptr_reg   <= (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign bus.busy        = busy_reg;
  assign bus.spi_start   = spi_start_reg;
  assign bus.spi_data_in = spi_data_in_reg;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed corner cases then random transactions,
// each checked against a transaction-level round-robin model.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_txn = 0;

  // Reference model state: round-robin pointer plus what the clients drive.
  int          m_ptr = 0;
  logic [NR-1:0] req_v = '0;
  logic [DW-1:0] data_v [NR];

  spi_master_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  spi_master_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_req();
    bus.req = req_v;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = data_v[i];
  endtask

  function automatic int model_pick(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++)
      if (r[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  function automatic logic noise();
    return ($urandom & 1) != 0;
  endfunction

  // Entered at an IDLE cycle with req_v/data_v already applied.
  // fin_dly = WAIT cycle in which the master finishes (0 = never).
  task automatic do_txn(input int fin_dly, input bit drop_req,
                        input logic [NR-1:0] raise_mask, input logic [DW-1:0] resp);
    int            w;
    logic [DW-1:0] word;
    logic [DW-1:0] exp_data;
    logic [NR-1:0] exp_cs;
    bit            to;
    w    = model_pick(req_v);
    word = data_v[w];
    check_val("busy_idle", bus.busy, 1'b0);

    tick();  // GRANT
    check_val("gnt", bus.gnt, NR'(1) << w);
    check_val("busy_grant", bus.busy, 1'b1);
    if (drop_req) req_v[w] = 1'b0;
    apply_req();
    bus.spi_finish   = noise();
    bus.spi_data_out = DW'($urandom);

    tick();  // START
    check_val("spi_start", bus.spi_start, 1'b1);
    check_val("spi_data_in", bus.spi_data_in, word);
    check_val("gnt_clear", bus.gnt, '0);
    bus.spi_finish = noise();

    for (int k = 1; k <= TO; k++) begin
      tick();  // WAIT cycle k
      check_val("rsp_valid_wait", bus.rsp_valid, '0);
      check_val("spi_start_wait", bus.spi_start, 1'b0);
      check_val("busy_wait", bus.busy, 1'b1);
      bus.spi_cs_in    = noise();
      bus.spi_finish   = (k == fin_dly);
      bus.spi_data_out = (k == fin_dly) ? resp : DW'($urandom);
      if (k == 2) begin
        req_v = req_v | raise_mask;
        apply_req();
      end
      #1;
      exp_cs    = '1;
      exp_cs[w] = bus.spi_cs_in;
      check_val("cs_n_wait", bus.cs_n, exp_cs);
      if (k == fin_dly) break;
    end

    tick();  // RESP
    to       = (fin_dly == 0);
    exp_data = to ? '0 : resp;
    check_val("rsp_valid", bus.rsp_valid, NR'(1) << w);
    check_val("rsp_data", bus.rsp_data, exp_data);
    check_val("rsp_timeout", bus.rsp_timeout, to);
    check_val("busy_resp", bus.busy, 1'b1);
    bus.spi_finish = noise();
    m_ptr = (w + 1) % NR;
    n_txn++;
    $display("txn %0d owner=%0d word=%02h rsp=%02h timeout=%0d", n_txn, w, word, exp_data, to);

    tick();  // IDLE
    bus.spi_finish = 1'b0;
    bus.spi_cs_in  = noise();
    #1;
    check_val("busy_after", bus.busy, 1'b0);
    check_val("rsp_valid_after", bus.rsp_valid, '0);
    check_val("rsp_data_hold", bus.rsp_data, exp_data);
    check_val("cs_n_idle", bus.cs_n, {NR{1'b1}});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) data_v[i] = '0;
    bus.req          = '0;
    bus.req_data     = '0;
    bus.spi_finish   = 1'b0;
    bus.spi_data_out = '0;
    bus.spi_cs_in    = 1'b1;
    #2 rst = 1'b1;
    #10;
    check_val("rst_state_busy", bus.busy, 1'b0);
    check_val("rst_gnt", bus.gnt, '0);
    check_val("rst_rsp_valid", bus.rsp_valid, '0);
    check_val("rst_rsp_data", bus.rsp_data, '0);
    check_val("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    check_val("rst_spi_start", bus.spi_start, 1'b0);
    check_val("rst_spi_data_in", bus.spi_data_in, '0);
    check_val("rst_cs_n", bus.cs_n, {NR{1'b1}});
    @(posedge clk); #1;
    rst = 1'b0;

    // All clients held high: strict rotation 0,1,2,3,0.
    for (int i = 0; i < NR; i++) data_v[i] = DW'($urandom);
    req_v = '1;
    apply_req();
    for (int t = 0; t < 5; t++) do_txn($urandom_range(1, TO), 1'b0, '0, DW'($urandom));

    // Single request from client 1.
    data_v[1] = 8'hA5;
    req_v     = 4'b0010;
    apply_req();
    do_txn(12, 1'b1, '0, 8'h3C);

    // Client 2 held, client 3 arrives mid-transaction: 2,3,2.
    req_v = 4'b0100;
    apply_req();
    do_txn(7, 1'b0, 4'b1000, DW'($urandom));
    do_txn(3, 1'b1, '0, DW'($urandom));
    do_txn(9, 1'b0, '0, DW'($urandom));

    // Watchdog expiry, then a normal transaction follows.
    req_v = 4'b0001;
    apply_req();
    do_txn(0, 1'b1, '0, DW'($urandom));
    req_v = 4'b0010;
    apply_req();
    do_txn(5, 1'b1, '0, DW'($urandom));

    // Finish coincides with the last watchdog cycle.
    req_v = 4'b1000;
    apply_req();
    do_txn(TO, 1'b1, '0, DW'($urandom));

    // Request withdrawn before the sampling edge: nothing granted.
    req_v = 4'b0110;
    apply_req();
    #3;
    req_v = '0;
    apply_req();
    tick();
    check_val("withdraw_gnt", bus.gnt, '0);
    check_val("withdraw_busy", bus.busy, 1'b0);

    // Move pointer to 2, then reset in the middle of client 2's WAIT.
    req_v = 4'b0010;
    apply_req();
    do_txn(4, 1'b1, '0, DW'($urandom));
    req_v = '1;
    apply_req();
    tick();
    check_val("rst_case_gnt", bus.gnt, NR'(1) << model_pick(req_v));
    tick();
    check_val("rst_case_start", bus.spi_start, 1'b1);
    repeat (3) begin
      tick();
      bus.spi_cs_in = 1'b0;
    end
    #1;
    check_val("rst_case_cs_low", bus.cs_n, 4'b1011);
    rst = 1'b1;
    #1;
    check_val("rst_case_cs_n", bus.cs_n, {NR{1'b1}});
    check_val("rst_case_busy", bus.busy, 1'b0);
    m_ptr = 0;
    repeat (2) begin
      tick();
      check_val("rst_case_no_rsp", bus.rsp_valid, '0);
    end
    rst = 1'b0;
    do_txn(6, 1'b1, '0, DW'($urandom));

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      if (($urandom & 3) == 0) begin
        req_v = '0;
        apply_req();
        repeat ($urandom_range(1, 3)) begin
          tick();
          check_val("gap_gnt", bus.gnt, '0);
          check_val("gap_busy", bus.busy, 1'b0);
        end
      end
      for (int i = 0; i < NR; i++) data_v[i] = DW'($urandom);
      req_v = NR'($urandom_range(1, (1 << NR) - 1));
      apply_req();
      do_txn($urandom_range(0, TO), noise(), NR'($urandom_range(0, (1 << NR) - 1)), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
